// File: rtl/rf_pkg.sv
// Purpose: shared sizes, index/data types and the hardwired-zero index for the RV32 integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; constants and types only).
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // x0 reads as zero and ignores writes
  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rf_read_port.sv
// Purpose: one combinational read port -- index mux, x0 zero-force, optional write-through (RF_BYPASS_EN).
// Latency: 0 cycles, rd_data follows rd_idx (and the write port when bypassing) combinationally.
// Backpressure: none; always ready, no flow control.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [2**ADDR_W-1:1][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                rd_idx,
`ifdef RF_BYPASS_EN
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_idx,
  input  logic [DATA_W-1:0]                wr_data,
`endif
  output logic [DATA_W-1:0]                rd_data
);

  // Select stored entry; x0 forced to zero; in-flight writeback wins when bypassing.
  always_comb begin
    rd_data = '0;
    if (rd_idx != ZERO_REG) begin
      rd_data = regs[rd_idx];
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_idx == rd_idx)) begin
        rd_data = wr_data;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// Purpose: RV32 integer register file, 32 x 32 bits, two combinational reads, one synchronous write; x0 hardwired zero.
// Latency: reads 0 cycles; a write is visible after the next rising clk (same cycle if RF_BYPASS_EN is defined).
// Backpressure: none; write accepted every cycle rf_we is high, reads always available.
module register_file
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] wR,
  input  logic [DATA_W-1:0] wD,
  input  logic [ADDR_W-1:0] rR1,
  input  logic [ADDR_W-1:0] rR2,
  output logic [DATA_W-1:0] rD1,
  output logic [DATA_W-1:0] rD2
);

  // Entry 0 is not stored: the read ports synthesise its zero value.
  logic [2**ADDR_W-1:1][DATA_W-1:0] regs;

  // Writeback commit; reset clears everything and beats a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (rf_we && (wR != ZERO_REG)) begin
      regs[wR] <= wD;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs    (regs),
    .rd_idx  (rR1),
`ifdef RF_BYPASS_EN
    .wr_en   (rf_we),
    .wr_idx  (wR),
    .wr_data (wD),
`endif
    .rd_data (rD1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs    (regs),
    .rd_idx  (rR2),
`ifdef RF_BYPASS_EN
    .wr_en   (rf_we),
    .wr_idx  (wR),
    .wr_data (wD),
`endif
    .rd_data (rD2)
  );

endmodule

// File: tb/tb_register_file.sv
// Purpose: directed and pseudo-random checks of register_file against hand values and a small golden model.
// Latency: expects 0-cycle reads and writes visible after the clock edge (or same cycle with RF_BYPASS_EN).
// Backpressure: n/a.
module tb_register_file;
  import rf_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      rf_we = 1'b0;
  reg_idx_t  wR = '0, rR1 = '0, rR2 = '0;
  reg_data_t wD = '0;
  reg_data_t rD1, rD2;

  int vectors = 0;
  int miscompares = 0;

  reg_data_t model [NUM_REGS];
  logic      written [NUM_REGS];

  register_file dut (
    .clk (clk), .rst (rst), .rf_we (rf_we), .wR (wR), .wD (wD),
    .rR1 (rR1), .rR2 (rR2), .rD1 (rD1), .rD2 (rD2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input reg_data_t obs, input reg_data_t exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) begin
      model[i]   = '0;
      written[i] = 1'b0;
    end
  endtask

  // one write cycle: drive after falling edge, commit on rising edge, return #1 after it
  task automatic wr(input reg_idx_t idx, input reg_data_t data);
    @(negedge clk);
    rf_we = 1'b1; wR = idx; wD = data;
    @(posedge clk);
    #1;
    rf_we = 1'b0;
    if (idx != 0) begin
      model[idx]   = data;
      written[idx] = 1'b1;
    end
  endtask

  task automatic rd(input reg_idx_t a, input reg_idx_t b, input string tag,
                    input reg_data_t e1, input reg_data_t e2);
    rR1 = a; rR2 = b;
    #1;
    chk({tag, ".rD1"}, rD1, e1);
    chk({tag, ".rD2"}, rD2, e2);
  endtask

  initial begin
    model_clear();

    // 1: reset holds everything at zero
    #2;
    for (int i = 0; i < NUM_REGS; i++) rd(reg_idx_t'(i), reg_idx_t'(NUM_REGS-1-i), "rst_read", '0, '0);
    @(negedge clk); rst = 1'b0;

    wr(5'd6, 32'hA5A5_A5A5);
    wr(5'd31, 32'h1234_5678);
    rd(6, 31, "pre_midrst", 32'hA5A5_A5A5, 32'h1234_5678);
    // mid-cycle async reset clears immediately without a clock edge
    @(negedge clk); #2;
    rst = 1'b1;
    rd(6, 31, "midrst", '0, '0);
    // reset beats a simultaneous write across a rising edge
    rf_we = 1'b1; wR = 5'd6; wD = 32'hFFFF_0000;
    @(posedge clk); #1;
    rd(6, 6, "rst_over_wr", '0, '0);
    rf_we = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_clear();

    // 2: basic writes and dual reads
    wr(1, 32'h1111_1111);
    wr(2, 32'h2222_2222);
    wr(3, 32'h3333_3333);
    wr(4, 32'h4444_4444);
    wr(7, 32'h0D00_0721);
    rd(1, 2, "rd_1_2", 32'h1111_1111, 32'h2222_2222);
    rd(7, 4, "rd_7_4", 32'h0D00_0721, 32'h4444_4444);
    rd(3, 0, "rd_3_0", 32'h3333_3333, 32'h0000_0000);

    // 3: x0 discards writes and is never bypassed
    @(negedge clk);
    rf_we = 1'b1; wR = 0; wD = 32'hFFFF_FFFF;
    rd(0, 1, "x0_inflight", 32'h0, 32'h1111_1111);
    @(posedge clk); #1; rf_we = 1'b0;
    rd(0, 1, "x0_after", 32'h0, 32'h1111_1111);

    // 4: same register on both ports; unwritten register
    rd(2, 2, "rd_2_2", 32'h2222_2222, 32'h2222_2222);
    rd(5, 5, "rd_unwritten", 32'h0, 32'h0);

    // 5: read of the register being written in the same cycle
    @(negedge clk);
    rf_we = 1'b1; wR = 9; wD = 32'hDEAD_BEEF; rR1 = 9; rR2 = 3;
    #1;
`ifdef RF_BYPASS_EN
    chk("same_cycle_rd1", rD1, 32'hDEAD_BEEF);
`else
    chk("same_cycle_rd1", rD1, 32'h0);
`endif
    chk("same_cycle_rd2", rD2, 32'h3333_3333);
    @(posedge clk); #1; rf_we = 1'b0;
    model[9] = 32'hDEAD_BEEF; written[9] = 1'b1;
    rd(9, 9, "after_edge", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // rf_we low: no state change
    @(negedge clk);
    rf_we = 1'b0; wR = 9; wD = 32'h0BAD_F00D;
    @(posedge clk); #1;
    rd(9, 1, "we_low", 32'hDEAD_BEEF, 32'h1111_1111);

    // 6: random writes against the golden model
    for (int n = 0; n < 40; n++) begin
      reg_idx_t  idx;
      reg_data_t dat;
      idx = reg_idx_t'($urandom_range(0, NUM_REGS-1));
      dat = $urandom;
      if (n % 8 == 0) idx = 0;
      wr(idx, dat);
      rd(0, idx, "rand_wr", 32'h0, model[idx]);
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (written[i]) rd(reg_idx_t'(i), 0, "rand_sweep", model[i], 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
